xbar_out_sched: RTL and testbench

Output-port scheduler for the crossbar. Shares one output port between `N_SRC` input FIFOs. Grants are round-robin, one fixed-length burst at a time. The scheduler pops the granted FIFO at full rate and absorbs the FIFO's 1-cycle registered read latency in a 2-entry output buffer. It also presents a valid/ready stream with a burst-last marker to the output link.

---
 rtl/xbar_pkg.sv | 21 ++
 rtl/rr_pick.sv | 27 ++
 rtl/xbar_out_sched.sv | 135 +++++++++++++
 tb/tb_xbar_out_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar types: scheduler FSM states, source-id width rule, output buffer entry.
package xbar_pkg;

  localparam int XBAR_DW    = 32;
  localparam int XBAR_N_SRC = 4;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} sched_state_t;

  // Source-id width for n requesters; a single requester still needs one bit.
  function automatic int src_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [src_id_w(XBAR_N_SRC)-1:0] src_id_t;

  typedef struct packed {
    logic [XBAR_DW-1:0] data;
    logic               last;
  } buf_entry_t;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first set request at or after last+1, wrapping at N-1.
module rr_pick import xbar_pkg::*; #(
  parameter  int N   = 4,
  localparam int IDW = src_id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] id,
  output logic           any
);

  logic [IDW-1:0] k;

  always_comb begin
    id  = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 1; i <= N; i++) begin
      k = IDW'((int'(last) + i) % N);
      if (!any && req[k]) begin
        any = 1'b1;
        id  = k;
      end
    end
  end

endmodule

// File: rtl/xbar_out_sched.sv
// Output-port scheduler: round-robin fixed-length bursts from N_SRC FIFOs into a
// 2-entry skid buffer that hides the FIFOs' registered read latency.
module xbar_out_sched import xbar_pkg::*; #(
  parameter  int N_SRC     = 4,
  parameter  int DWIDTH    = XBAR_DW,
  parameter  int BURST_LEN = 4,
  localparam int IDW       = src_id_w(N_SRC)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_SRC-1:0]             src_not_empty,
  output logic [N_SRC-1:0]             src_pop,
  input  logic [N_SRC-1:0][DWIDTH-1:0] src_data,
  output logic [DWIDTH-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         gnt_valid,
  output logic [IDW-1:0]               gnt_id
);

  localparam int            CW        = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN);

  sched_state_t     state_q, state_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   last_gnt_q, last_gnt_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             inflight_q, inflight_d;
  logic [IDW-1:0]   infl_id_q, infl_id_d;
  logic             infl_last_q, infl_last_d;
  buf_entry_t [1:0] buf_q, buf_d;
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;

  logic [IDW-1:0]   pick_id;
  logic             pick_any;
  logic             deq, room, pop;
  logic [CW-1:0]    beat_inc;

  rr_pick #(.N(N_SRC)) u_pick (
    .req  (src_not_empty),
    .last (last_gnt_q),
    .id   (pick_id),
    .any  (pick_any)
  );

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_q[rd_ptr_q].data;
  assign m_last    = buf_q[rd_ptr_q].last;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign src_pop   = pop ? (N_SRC'(1) << gnt_id_q) : '0;

  always_comb begin
    deq      = m_valid & m_ready;
    // Count the word already in flight so the buffer can never be overrun.
    room     = (({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, deq}) < 3'd2);
    pop      = aresetn && (state_q == BURST) && src_not_empty[gnt_id_q] &&
               (beat_cnt_q < LAST_BEAT) && room;
    beat_inc = beat_cnt_q + 1'b1;

    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_gnt_d  = last_gnt_q;
    beat_cnt_d  = beat_cnt_q;

    if (state_q == IDLE) begin
      if (pick_any) begin
        state_d     = BURST;
        gnt_valid_d = 1'b1;
        gnt_id_d    = pick_id;
        last_gnt_d  = pick_id;
        beat_cnt_d  = '0;
      end
    end else if (pop) begin
      beat_cnt_d = beat_inc;
      if (beat_inc == LAST_BEAT) begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    end

    // The pop's source travels with it, so a grant change cannot misroute the capture.
    inflight_d  = pop;
    infl_id_d   = pop ? gnt_id_q : infl_id_q;
    infl_last_d = pop && (beat_inc == LAST_BEAT);

    buf_d    = buf_q;
    occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, deq};
    wr_ptr_d = wr_ptr_q ^ inflight_q;
    rd_ptr_d = rd_ptr_q ^ deq;
    if (inflight_q) begin
      buf_d[wr_ptr_q].data = src_data[infl_id_q];
      buf_d[wr_ptr_q].last = infl_last_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_gnt_q  <= IDW'(N_SRC - 1);
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      infl_id_q   <= '0;
      infl_last_q <= 1'b0;
      buf_q       <= '0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      last_gnt_q  <= last_gnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      infl_id_q   <= infl_id_d;
      infl_last_q <= infl_last_d;
      buf_q       <= buf_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  a_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
    !(inflight_q && (occ_q == 2'd2)));

endmodule

// File: tb/tb_xbar_out_sched.sv
// Scoreboard bench for xbar_out_sched: behavioural FIFOs, expected-word queue, grant log.
module tb_xbar_out_sched;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BL = 4;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [N-1:0]          src_not_empty;
  logic [N-1:0]          src_pop;
  logic [N-1:0][DW-1:0]  src_data = '0;
  logic [DW-1:0]         m_data;
  logic                  m_valid, m_last, gnt_valid;
  logic                  m_ready = 1'b1;
  logic [1:0]            gnt_id;

  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t sb[$];
  int   gq[$];
  int   gapq[$];
  int   n_tests = 0, n_fail = 0;

  logic [DW-1:0] mem [N][64];
  int  wp[N];
  int  rp[N];
  bit  flush = 1'b0;

  xbar_out_sched #(.N_SRC(N), .DWIDTH(DW), .BURST_LEN(BL)) dut (
    .aclk(aclk), .aresetn(aresetn), .src_not_empty(src_not_empty), .src_pop(src_pop),
    .src_data(src_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .gnt_valid(gnt_valid), .gnt_id(gnt_id));

  always #5 aclk = ~aclk;

  always_comb begin
    src_not_empty = '0;
    for (int s = 0; s < N; s++) src_not_empty[s] = (wp[s] != rp[s]);
  end

  // FIFO model with a registered read port.
  always @(posedge aclk) begin
    for (int s = 0; s < N; s++) begin
      if (flush) rp[s] <= wp[s];
      else if (src_pop[s]) begin
        src_data[s] <= mem[s][rp[s] % 64];
        rp[s]       <= rp[s] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int s, input int k);
    return 32'hA000_0000 + 32'(s * 256 + k);
  endfunction

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic fifo_put(input int s, input logic [31:0] d);
    mem[s][wp[s] % 64] = d;
    wp[s] = wp[s] + 1;
  endtask

  task automatic exp_put(input logic [31:0] d, input logic l);
    exp_t e;
    e.d = d; e.l = l;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    step();
    aresetn = 1'b0;
    flush   = 1'b1;
    repeat (2) step();
    flush = 1'b0;
    sb.delete(); gq.delete(); gapq.delete();
    aresetn = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int cnt = 0;
    while (sb.size() != 0 && cnt < 300) begin step(); cnt++; end
    if (sb.size() != 0) chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: scoreboard pops, stall stability, grant order and gap length.
  bit          hold_q = 1'b0;
  logic [31:0] hold_data = '0;
  bit          gv_prev = 1'b0;
  int          low_cnt = 0;
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      hold_q  = 1'b0;
      gv_prev = 1'b0;
      low_cnt = 0;
    end else begin
      if (hold_q) begin
        chk("m_valid_held", 32'(m_valid), 32'd1);
        chk("m_data_stable", m_data, hold_data);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("unexpected_word", m_data, 32'd0);
        else begin
          e = sb.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", 32'(m_last), 32'(e.l));
        end
      end
      hold_q    = m_valid && !m_ready;
      hold_data = m_data;
      if (!gnt_valid) low_cnt++;
      if (gnt_valid && !gv_prev) begin
        gq.push_back(int'(gnt_id));
        gapq.push_back(low_cnt);
        low_cnt = 0;
      end
      gv_prev = gnt_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:9] pat = 10'b1111001011;
    int n, cnt;
    for (int s = 0; s < N; s++) wp[s] = 0;

    // Reset state
    do_reset();
    @(negedge aclk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_gnt_valid", 32'(gnt_valid), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_src_pop", 32'(src_pop), 0);

    // Single source, full rate: cycle-exact timing
    do_reset();
    for (int k = 0; k < 4; k++) begin fifo_put(0, word(0, k)); exp_put(word(0, k), k == 3); end
    for (int rel = 0; rel <= 7; rel++) begin
      @(negedge aclk);
      chk($sformatf("t1_pop_c%0d", rel), 32'(src_pop), (rel >= 1 && rel <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("t1_valid_c%0d", rel), 32'(m_valid), (rel >= 3 && rel <= 6) ? 32'd1 : 32'd0);
      chk($sformatf("t1_gnt_c%0d", rel), 32'(gnt_valid), (rel >= 1 && rel <= 4) ? 32'd1 : 32'd0);
      if (rel == 1) chk("t1_gnt_id", 32'(gnt_id), 0);
    end
    wait_drain("t1_drain");

    // Round-robin fairness between sources 1 and 3
    do_reset();
    for (int k = 0; k < 8; k++) begin fifo_put(1, word(1, k)); fifo_put(3, word(3, k)); end
    for (int b = 0; b < 2; b++)
      for (int s = 1; s <= 3; s += 2)
        for (int k = 0; k < 4; k++) exp_put(word(s, b * 4 + k), k == 3);
    wait_drain("rr_drain");
    chk("rr_ngrants", 32'(gq.size()), 4);
    if (gq.size() == 4) begin
      chk("rr_g0", 32'(gq[0]), 1); chk("rr_g1", 32'(gq[1]), 3);
      chk("rr_g2", 32'(gq[2]), 1); chk("rr_g3", 32'(gq[3]), 3);
      for (int g = 1; g < 4; g++) chk($sformatf("rr_gap%0d", g), 32'(gapq[g]), 1);
    end

    // Wrap-around: last grant was 3, sources 0 and 2 request
    repeat (3) step();
    gq.delete();
    for (int k = 0; k < 4; k++) begin fifo_put(0, word(0, 16 + k)); fifo_put(2, word(2, 16 + k)); end
    for (int k = 0; k < 4; k++) exp_put(word(0, 16 + k), k == 3);
    for (int k = 0; k < 4; k++) exp_put(word(2, 16 + k), k == 3);
    wait_drain("wrap_drain");
    chk("wrap_ngrants", 32'(gq.size()), 2);
    if (gq.size() == 2) begin
      chk("wrap_g0", 32'(gq[0]), 0);
      chk("wrap_g1", 32'(gq[1]), 2);
    end

    // Backpressure on a 4-word burst
    do_reset();
    for (int k = 0; k < 4; k++) begin fifo_put(0, word(0, 32 + k)); exp_put(word(0, 32 + k), k == 3); end
    for (int i = 0; i < 20; i++) begin
      m_ready = (i < 10) ? pat[i] : 1'b1;
      step();
    end
    m_ready = 1'b1;
    wait_drain("bp_drain");

    // Source starvation mid-burst on source 2
    do_reset();
    fifo_put(2, word(2, 40)); fifo_put(2, word(2, 41));
    for (int k = 0; k < 4; k++) exp_put(word(2, 40 + k), k == 3);
    exp_put(word(3, 40), 1'b0);
    @(negedge aclk);
    for (int rel = 1; rel <= 8; rel++) begin
      step();
      if (rel == 2) fifo_put(3, word(3, 40));
      if (rel == 5) begin fifo_put(2, word(2, 42)); fifo_put(2, word(2, 43)); end
      @(negedge aclk);
      if (rel <= 6) begin
        chk($sformatf("st_gnt_c%0d", rel), 32'(gnt_valid), 1);
        chk($sformatf("st_id_c%0d", rel), 32'(gnt_id), 2);
      end
      if (rel == 3 || rel == 4) chk($sformatf("st_stall_c%0d", rel), 32'(src_pop), 0);
    end
    wait_drain("st_drain");
    chk("st_ngrants", 32'(gq.size()), 2);
    if (gq.size() == 2) begin
      chk("st_g0", 32'(gq[0]), 2);
      chk("st_g1", 32'(gq[1]), 3);
    end

    // Reset mid-burst after the second pop
    do_reset();
    for (int k = 0; k < 4; k++) fifo_put(1, word(1, 48 + k));
    n = 0; cnt = 0;
    while (n < 2 && cnt < 20) begin
      @(negedge aclk);
      if (|src_pop) n++;
      cnt++;
    end
    if (n < 2) chk("mr_pops", 32'(n), 2);
    step();
    aresetn = 1'b0;
    for (int k = 0; k < 4; k++) fifo_put(3, word(3, 48 + k));
    sb.delete();
    @(negedge aclk);
    chk("mr_pop_in_reset", 32'(src_pop), 0);
    step();
    aresetn = 1'b1;
    exp_put(word(1, 50), 1'b0);
    exp_put(word(1, 51), 1'b0);
    @(negedge aclk);
    chk("mr_m_valid", 32'(m_valid), 0);
    chk("mr_gnt_valid", 32'(gnt_valid), 0);
    chk("mr_src_pop", 32'(src_pop), 0);
    @(negedge aclk);
    chk("mr_regnt_valid", 32'(gnt_valid), 1);
    chk("mr_regnt_id", 32'(gnt_id), 1);
    wait_drain("mr_drain");

    do_reset();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
